// File: rtl/icb_bus_pkg.sv
// Shared ICB field widths and arbiter constants used across the bus fabric.
package icb_bus_pkg;
  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int MASK_W        = 4;
  localparam int ICB_ARB_PORTS = 3;
  localparam int IDX_W         = 2;

  // Next initiator index in round-robin order, wrapping after the last port.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(ICB_ARB_PORTS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction
endpackage

// File: rtl/fifo_based_on_regs.sv
// Register-based FIFO; in first-word-fall-through mode the head entry is visible on o_dout.
module fifo_based_on_regs #(
  parameter string fwft_mode        = "true",
  parameter string low_latency_mode = "false",
  parameter int    fifo_depth       = 4,
  parameter int    fifo_data_width  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wen,
  input  logic [fifo_data_width-1:0] i_din,
  output logic                       o_full_n,
  input  logic                       i_ren,
  output logic [fifo_data_width-1:0] o_dout,
  output logic                       o_empty_n
);
  localparam int AW = $clog2(fifo_depth);

  if (fwft_mode != "true" || low_latency_mode != "false") begin : g_bad_mode
    $error("fifo_based_on_regs: only fwft_mode=true, low_latency_mode=false is implemented");
  end

  logic [fifo_data_width-1:0] r_mem [fifo_depth];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [AW:0]                r_count;
  logic                       w_wr;
  logic                       w_rd;

  // No write-through: a full FIFO refuses the write even if a read retires this cycle.
  assign w_wr      = i_wen & o_full_n;
  assign w_rd      = i_ren & o_empty_n;
  assign o_full_n  = (r_count != (AW+1)'(fifo_depth));
  assign o_empty_n = (r_count != '0);
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/rr_arb_3.sv
// Three-way round-robin arbiter with a grant lock that pins the winner while the target stalls.
module rr_arb_3
  import icb_bus_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ICB_ARB_PORTS-1:0] i_req,
  input  logic                     i_hs,
  input  logic                     i_stall,
  output logic [IDX_W-1:0]         o_gnt_idx,
  output logic                     o_gnt_vld
);
  logic [IDX_W-1:0] r_prio_ptr;
  logic             r_lock;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_vld;

  // While locked the grant ignores the request vector entirely.
  always_comb begin
    w_gnt_idx = '0;
    w_gnt_vld = 1'b0;
    w_cand    = r_prio_ptr;
    if (r_lock) begin
      w_gnt_idx = r_lock_idx;
      w_gnt_vld = 1'b1;
    end else begin
      for (int k = 0; k < ICB_ARB_PORTS; k++) begin
        if (!w_gnt_vld && i_req[w_cand]) begin
          w_gnt_idx = w_cand;
          w_gnt_vld = 1'b1;
        end
        w_cand = rr_next(w_cand);
      end
    end
  end

  assign o_gnt_idx = w_gnt_idx;
  assign o_gnt_vld = w_gnt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_ptr <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (i_hs) begin
      r_prio_ptr <= rr_next(w_gnt_idx);
      r_lock     <= 1'b0;
    end else if (i_stall) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_gnt_idx;
    end
  end
endmodule

// File: rtl/icb_3s_to_1m_arb.sv
// Merges three ICB initiators onto one target port; responses return in order via a route FIFO.
module icb_3s_to_1m_arb
  import icb_bus_pkg::*;
#(
  parameter int outstanding_depth = 4,
  parameter int simulation_delay  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s0_icb_cmd_addr,
  input  logic              s0_icb_cmd_read,
  input  logic [DATA_W-1:0] s0_icb_cmd_wdata,
  input  logic [MASK_W-1:0] s0_icb_cmd_wmask,
  input  logic              s0_icb_cmd_valid,
  output logic              s0_icb_cmd_ready,
  output logic [DATA_W-1:0] s0_icb_rsp_rdata,
  output logic              s0_icb_rsp_err,
  output logic              s0_icb_rsp_valid,
  input  logic              s0_icb_rsp_ready,
  input  logic [ADDR_W-1:0] s1_icb_cmd_addr,
  input  logic              s1_icb_cmd_read,
  input  logic [DATA_W-1:0] s1_icb_cmd_wdata,
  input  logic [MASK_W-1:0] s1_icb_cmd_wmask,
  input  logic              s1_icb_cmd_valid,
  output logic              s1_icb_cmd_ready,
  output logic [DATA_W-1:0] s1_icb_rsp_rdata,
  output logic              s1_icb_rsp_err,
  output logic              s1_icb_rsp_valid,
  input  logic              s1_icb_rsp_ready,
  input  logic [ADDR_W-1:0] s2_icb_cmd_addr,
  input  logic              s2_icb_cmd_read,
  input  logic [DATA_W-1:0] s2_icb_cmd_wdata,
  input  logic [MASK_W-1:0] s2_icb_cmd_wmask,
  input  logic              s2_icb_cmd_valid,
  output logic              s2_icb_cmd_ready,
  output logic [DATA_W-1:0] s2_icb_rsp_rdata,
  output logic              s2_icb_rsp_err,
  output logic              s2_icb_rsp_valid,
  input  logic              s2_icb_rsp_ready,
  output logic [ADDR_W-1:0] m_icb_cmd_addr,
  output logic              m_icb_cmd_read,
  output logic [DATA_W-1:0] m_icb_cmd_wdata,
  output logic [MASK_W-1:0] m_icb_cmd_wmask,
  output logic              m_icb_cmd_valid,
  input  logic              m_icb_cmd_ready,
  input  logic [DATA_W-1:0] m_icb_rsp_rdata,
  input  logic              m_icb_rsp_err,
  input  logic              m_icb_rsp_valid,
  output logic              m_icb_rsp_ready
);
  if (outstanding_depth < 2 || (outstanding_depth & (outstanding_depth - 1)) != 0 ||
      simulation_delay < 0) begin : g_bad_param
    $error("icb_3s_to_1m_arb: outstanding_depth must be a power of 2 >= 2");
  end

  // Handshake rule on every channel: a transfer happens in a cycle where valid and ready are both 1.
  logic [ICB_ARB_PORTS-1:0] w_req;
  logic [ADDR_W-1:0]        w_addr  [ICB_ARB_PORTS];
  logic                     w_read  [ICB_ARB_PORTS];
  logic [DATA_W-1:0]        w_wdata [ICB_ARB_PORTS];
  logic [MASK_W-1:0]        w_wmask [ICB_ARB_PORTS];
  logic [IDX_W-1:0]         w_gnt_idx;
  logic                     w_gnt_vld;
  logic                     w_route_full_n;
  logic                     w_route_empty_n;
  logic [IDX_W-1:0]         w_dst;
  logic                     w_cmd_hs;
  logic                     w_stall;
  logic                     w_rsp_hs;
  logic                     w_sel_ready;
  logic                     w_to_s0, w_to_s1, w_to_s2;

  assign w_req      = {s2_icb_cmd_valid, s1_icb_cmd_valid, s0_icb_cmd_valid};
  assign w_addr[0]  = s0_icb_cmd_addr;
  assign w_addr[1]  = s1_icb_cmd_addr;
  assign w_addr[2]  = s2_icb_cmd_addr;
  assign w_read[0]  = s0_icb_cmd_read;
  assign w_read[1]  = s1_icb_cmd_read;
  assign w_read[2]  = s2_icb_cmd_read;
  assign w_wdata[0] = s0_icb_cmd_wdata;
  assign w_wdata[1] = s1_icb_cmd_wdata;
  assign w_wdata[2] = s2_icb_cmd_wdata;
  assign w_wmask[0] = s0_icb_cmd_wmask;
  assign w_wmask[1] = s1_icb_cmd_wmask;
  assign w_wmask[2] = s2_icb_cmd_wmask;

  rr_arb_3 u_arb (
    .clk       (clk),
    .rst_n     (resetn),
    .i_req     (w_req),
    .i_hs      (w_cmd_hs),
    .i_stall   (w_stall),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  always_comb begin
    m_icb_cmd_addr  = '0;
    m_icb_cmd_read  = 1'b0;
    m_icb_cmd_wdata = '0;
    m_icb_cmd_wmask = '0;
    m_icb_cmd_valid = 1'b0;
    if (w_gnt_vld) begin
      m_icb_cmd_addr  = w_addr[w_gnt_idx];
      m_icb_cmd_read  = w_read[w_gnt_idx];
      m_icb_cmd_wdata = w_wdata[w_gnt_idx];
      m_icb_cmd_wmask = w_wmask[w_gnt_idx];
      m_icb_cmd_valid = w_req[w_gnt_idx] & w_route_full_n;
    end
  end

  assign w_cmd_hs         = m_icb_cmd_valid & m_icb_cmd_ready;
  assign w_stall          = m_icb_cmd_valid & ~m_icb_cmd_ready;
  assign w_sel_ready      = w_gnt_vld & w_route_full_n & m_icb_cmd_ready;
  assign s0_icb_cmd_ready = w_sel_ready & (w_gnt_idx == IDX_W'(0));
  assign s1_icb_cmd_ready = w_sel_ready & (w_gnt_idx == IDX_W'(1));
  assign s2_icb_cmd_ready = w_sel_ready & (w_gnt_idx == IDX_W'(2));

  fifo_based_on_regs #(
    .fwft_mode        ("true"),
    .low_latency_mode ("false"),
    .fifo_depth       (outstanding_depth),
    .fifo_data_width  (IDX_W)
  ) u_route_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .i_wen     (w_cmd_hs),
    .i_din     (w_gnt_idx),
    .o_full_n  (w_route_full_n),
    .i_ren     (w_rsp_hs),
    .o_dout    (w_dst),
    .o_empty_n (w_route_empty_n)
  );

  // An empty route FIFO means any response is stray and is left unacknowledged.
  assign w_to_s0 = w_route_empty_n & (w_dst == IDX_W'(0));
  assign w_to_s1 = w_route_empty_n & (w_dst == IDX_W'(1));
  assign w_to_s2 = w_route_empty_n & (w_dst == IDX_W'(2));

  assign s0_icb_rsp_valid = w_to_s0 & m_icb_rsp_valid;
  assign s1_icb_rsp_valid = w_to_s1 & m_icb_rsp_valid;
  assign s2_icb_rsp_valid = w_to_s2 & m_icb_rsp_valid;
  assign s0_icb_rsp_rdata = w_to_s0 ? m_icb_rsp_rdata : '0;
  assign s1_icb_rsp_rdata = w_to_s1 ? m_icb_rsp_rdata : '0;
  assign s2_icb_rsp_rdata = w_to_s2 ? m_icb_rsp_rdata : '0;
  assign s0_icb_rsp_err   = w_to_s0 & m_icb_rsp_err;
  assign s1_icb_rsp_err   = w_to_s1 & m_icb_rsp_err;
  assign s2_icb_rsp_err   = w_to_s2 & m_icb_rsp_err;

  assign m_icb_rsp_ready = (w_to_s0 & s0_icb_rsp_ready) | (w_to_s1 & s1_icb_rsp_ready) |
                           (w_to_s2 & s2_icb_rsp_ready);
  assign w_rsp_hs        = m_icb_rsp_valid & m_icb_rsp_ready;
endmodule

// File: tb/tb_icb_3s_to_1m_arb.sv
// Bench for icb_3s_to_1m_arb: directed scenarios plus random traffic against a queue-based model.
module tb_icb_3s_to_1m_arb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_addr  [3];
  logic        s_read  [3];
  logic [31:0] s_wdata [3];
  logic [3:0]  s_wmask [3];
  logic [2:0]  s_valid;
  logic [2:0]  s_rsp_ready;
  wire  [2:0]  s_cmd_ready;
  wire  [2:0]  s_rsp_valid;
  wire  [2:0]  s_rsp_err;
  wire  [31:0] s_rsp_rdata [3];
  wire  [31:0] m_addr;
  wire         m_read;
  wire  [31:0] m_wdata;
  wire  [3:0]  m_wmask;
  wire         m_cmd_valid;
  logic        m_cmd_ready;
  logic [31:0] m_rsp_rdata;
  logic        m_rsp_err;
  logic        m_rsp_valid;
  wire         m_rsp_ready;

  icb_3s_to_1m_arb #(.outstanding_depth(DEPTH), .simulation_delay(1)) dut (
    .clk(clk), .resetn(resetn),
    .s0_icb_cmd_addr(s_addr[0]), .s0_icb_cmd_read(s_read[0]), .s0_icb_cmd_wdata(s_wdata[0]),
    .s0_icb_cmd_wmask(s_wmask[0]), .s0_icb_cmd_valid(s_valid[0]), .s0_icb_cmd_ready(s_cmd_ready[0]),
    .s0_icb_rsp_rdata(s_rsp_rdata[0]), .s0_icb_rsp_err(s_rsp_err[0]),
    .s0_icb_rsp_valid(s_rsp_valid[0]), .s0_icb_rsp_ready(s_rsp_ready[0]),
    .s1_icb_cmd_addr(s_addr[1]), .s1_icb_cmd_read(s_read[1]), .s1_icb_cmd_wdata(s_wdata[1]),
    .s1_icb_cmd_wmask(s_wmask[1]), .s1_icb_cmd_valid(s_valid[1]), .s1_icb_cmd_ready(s_cmd_ready[1]),
    .s1_icb_rsp_rdata(s_rsp_rdata[1]), .s1_icb_rsp_err(s_rsp_err[1]),
    .s1_icb_rsp_valid(s_rsp_valid[1]), .s1_icb_rsp_ready(s_rsp_ready[1]),
    .s2_icb_cmd_addr(s_addr[2]), .s2_icb_cmd_read(s_read[2]), .s2_icb_cmd_wdata(s_wdata[2]),
    .s2_icb_cmd_wmask(s_wmask[2]), .s2_icb_cmd_valid(s_valid[2]), .s2_icb_cmd_ready(s_cmd_ready[2]),
    .s2_icb_rsp_rdata(s_rsp_rdata[2]), .s2_icb_rsp_err(s_rsp_err[2]),
    .s2_icb_rsp_valid(s_rsp_valid[2]), .s2_icb_rsp_ready(s_rsp_ready[2]),
    .m_icb_cmd_addr(m_addr), .m_icb_cmd_read(m_read), .m_icb_cmd_wdata(m_wdata),
    .m_icb_cmd_wmask(m_wmask), .m_icb_cmd_valid(m_cmd_valid), .m_icb_cmd_ready(m_cmd_ready),
    .m_icb_rsp_rdata(m_rsp_rdata), .m_icb_rsp_err(m_rsp_err),
    .m_icb_rsp_valid(m_rsp_valid), .m_icb_rsp_ready(m_rsp_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state: priority pointer, lock, and the ordered queue of response owners
  int m_ptr, m_lock_idx;
  bit m_lock;
  int route_q[$];
  int e_g;
  bit e_cmd_hs, e_stall, e_rsp_hs;
  int n_tests = 0;
  int n_fail  = 0;
  int rr_order[6] = '{0, 1, 2, 0, 1, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_lock_idx = 0;
    route_q.delete();
  endtask

  task automatic model_check();
    int g, dst;
    bit full, ev;
    full = (route_q.size() >= DEPTH);
    g = -1;
    if (m_lock) g = m_lock_idx;
    else
      for (int k = 0; k < 3; k++)
        if (g < 0 && s_valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    ev = (g >= 0) && s_valid[g] && !full;
    chk("m_cmd_valid", m_cmd_valid, ev);
    chk("m_cmd_addr",  m_addr,  (g >= 0) ? s_addr[g]  : 32'h0);
    chk("m_cmd_read",  m_read,  (g >= 0) ? s_read[g]  : 1'b0);
    chk("m_cmd_wdata", m_wdata, (g >= 0) ? s_wdata[g] : 32'h0);
    chk("m_cmd_wmask", m_wmask, (g >= 0) ? s_wmask[g] : 4'h0);
    dst = (route_q.size() > 0) ? route_q[0] : -1;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("s%0d_cmd_ready", n), s_cmd_ready[n], (g == n) && !full && m_cmd_ready);
      chk($sformatf("s%0d_rsp_valid", n), s_rsp_valid[n], (dst == n) && m_rsp_valid);
      chk($sformatf("s%0d_rsp_rdata", n), s_rsp_rdata[n], (dst == n) ? m_rsp_rdata : 32'h0);
      chk($sformatf("s%0d_rsp_err", n),   s_rsp_err[n],   (dst == n) && m_rsp_err);
    end
    chk("m_rsp_ready", m_rsp_ready, (dst >= 0) && s_rsp_ready[dst]);
    e_g      = g;
    e_cmd_hs = ev && m_cmd_ready;
    e_stall  = ev && !m_cmd_ready;
    e_rsp_hs = (dst >= 0) && m_rsp_valid && s_rsp_ready[dst];
  endtask

  task automatic model_update();
    if (!resetn) model_reset();
    else begin
      if (e_rsp_hs) void'(route_q.pop_front());
      if (e_cmd_hs) begin
        route_q.push_back(e_g);
        m_ptr  = (e_g + 1) % 3;
        m_lock = 0;
      end else if (e_stall) begin
        m_lock     = 1;
        m_lock_idx = e_g;
      end
    end
  endtask

  // driver tasks
  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 3; n++) begin
      s_addr[n] = '0; s_read[n] = 1'b0; s_wdata[n] = '0; s_wmask[n] = '0;
    end
    s_valid = '0; s_rsp_ready = '0;
    m_cmd_ready = 1'b0; m_rsp_rdata = '0; m_rsp_err = 1'b0; m_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    settle();
    advance();
    resetn = 1'b1;
  endtask

  function automatic int granted();
    for (int n = 0; n < 3; n++) if (s_cmd_ready[n]) return n;
    return 7;
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    // reset state: a stray response is neither forwarded nor acknowledged
    m_rsp_valid = 1'b1; s_rsp_ready = 3'b111;
    #2;
    chk("rst_m_cmd_valid", m_cmd_valid, 1'b0);
    chk("rst_m_rsp_ready", m_rsp_ready, 1'b0);
    chk("rst_s_rsp_valid", s_rsp_valid, 3'b000);
    settle();
    advance();

    // single initiator: two reads from s1
    do_reset();
    s_valid = 3'b010; s_read[1] = 1'b1; s_addr[1] = 32'h4000_0000;
    m_cmd_ready = 1'b1; s_rsp_ready = 3'b111;
    settle();
    chk("t1_cmd0_addr", m_addr, 32'h4000_0000);
    chk("t1_cmd0_ready", s_cmd_ready[1], 1'b1);
    advance();
    s_addr[1] = 32'h4000_0004;
    m_rsp_valid = 1'b1; m_rsp_rdata = 32'hA5A5_0001;
    settle();
    chk("t1_rsp0_valid", s_rsp_valid, 3'b010);
    chk("t1_rsp0_rdata", s_rsp_rdata[1], 32'hA5A5_0001);
    chk("t1_rsp0_err", s_rsp_err[1], 1'b0);
    advance();
    s_valid = 3'b000; m_rsp_rdata = 32'hA5A5_0002;
    settle();
    chk("t1_rsp1_valid", s_rsp_valid, 3'b010);
    chk("t1_rsp1_rdata", s_rsp_rdata[1], 32'hA5A5_0002);
    advance();
    m_rsp_valid = 1'b0;
    settle();
    chk("t1_drained", m_rsp_ready, 1'b0);
    advance();

    // round-robin with all three requesting
    do_reset();
    s_valid = 3'b111; s_addr[0] = 32'h100; s_addr[1] = 32'h200; s_addr[2] = 32'h300;
    m_cmd_ready = 1'b1; m_rsp_valid = 1'b1; s_rsp_ready = 3'b111;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("rr_grant%0d", i), granted(), rr_order[i]);
      advance();
    end

    // grant lock: s2 stalls three cycles while s0 waits
    do_reset();
    s_valid = 3'b010; m_cmd_ready = 1'b1;
    settle();
    advance();
    s_valid = 3'b101; s_addr[2] = 32'h2000_0020; s_addr[0] = 32'h0000_0100;
    m_cmd_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk($sformatf("lock_addr_c%0d", c), m_addr, 32'h2000_0020);
      advance();
    end
    m_cmd_ready = 1'b1;
    settle();
    chk("lock_s2_hs", s_cmd_ready, 3'b100);
    advance();
    s_valid = 3'b001;
    settle();
    chk("lock_s0_next", s_cmd_ready, 3'b001);
    chk("lock_s0_addr", m_addr, 32'h0000_0100);
    advance();

    // full route FIFO blocks commands until a response retires
    do_reset();
    s_valid = 3'b001; m_cmd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      s_addr[0] = 32'h1000 + 32'(i * 4);
      settle();
      advance();
    end
    settle();
    chk("full_m_valid", m_cmd_valid, 1'b0);
    chk("full_s_ready", s_cmd_ready, 3'b000);
    advance();
    m_rsp_valid = 1'b1; m_rsp_rdata = 32'hBEEF_0000; s_rsp_ready = 3'b001;
    settle();
    chk("full_rsp_ready", m_rsp_ready, 1'b1);
    chk("full_no_bypass", m_cmd_valid, 1'b0);
    advance();
    m_rsp_valid = 1'b0;
    settle();
    chk("full_fifth_valid", m_cmd_valid, 1'b1);
    chk("full_fifth_ready", s_cmd_ready[0], 1'b1);
    advance();
    s_valid = 3'b000;

    // response backpressure from s0
    m_rsp_valid = 1'b1; m_rsp_rdata = 32'h5A5A_1234; m_rsp_err = 1'b1; s_rsp_ready = 3'b000;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("bp_m_rsp_ready%0d", c), m_rsp_ready, 1'b0);
      chk($sformatf("bp_rdata%0d", c), s_rsp_rdata[0], 32'h5A5A_1234);
      chk($sformatf("bp_err%0d", c), s_rsp_err[0], 1'b1);
      advance();
    end
    s_rsp_ready = 3'b001;
    settle();
    chk("bp_release", m_rsp_ready, 1'b1);
    advance();
    settle();
    advance();

    // reset with two commands outstanding
    m_rsp_valid = 1'b1; s_rsp_ready = 3'b111;
    chk("mid_outstanding", route_q.size(), 2);
    resetn = 1'b0;
    #1;
    chk("mid_rsp_valid", s_rsp_valid, 3'b000);
    chk("mid_m_rsp_ready", m_rsp_ready, 1'b0);
    chk("mid_route_empty_n", dut.w_route_empty_n, 1'b0);
    chk("mid_prio_ptr", dut.u_arb.r_prio_ptr, 2'd0);
    model_reset();
    settle();
    advance();
    resetn = 1'b1;

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s_valid = 3'($urandom_range(0, 7));
      for (int n = 0; n < 3; n++) begin
        s_addr[n]  = $urandom;
        s_wdata[n] = $urandom;
        s_read[n]  = 1'($urandom_range(0, 1));
        s_wmask[n] = 4'($urandom_range(0, 15));
      end
      s_rsp_ready = 3'($urandom_range(0, 7));
      m_cmd_ready = ($urandom_range(0, 9) < 7);
      m_rsp_valid = ($urandom_range(0, 9) < 6);
      m_rsp_rdata = $urandom;
      m_rsp_err   = 1'($urandom_range(0, 1));
      settle();
      advance();
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icb_3s_to_1m_arb.md
# icb_3s_to_1m_arb

Three-initiator to one-target ICB arbiter. It merges the command channels of three ICB initiators (for example the CPU instruction port, the CPU data port, and a DMA) onto one shared ICB master port. Arbitration is round-robin with a grant lock that keeps the command stable. Each response is returned in order to the initiator that issued the matching command, using an internal route FIFO. The block sits upstream of the ICB address distributor in the SoC bus fabric.

## Interface
Parameters:
- outstanding_depth, 4: maximum commands accepted but not yet responded to. Must be a power of 2, at least 2.
- simulation_delay, 1: register update delay used in simulation only.

Ports (reset is asynchronous and active-low, as already decided):
- clk  in  1  single clock for the whole block
- resetn  in  1  asynchronous active-low reset
- sN_icb_cmd_addr / _read / _wdata / _wmask, for N = 0,1,2:
  - directions and widths: in, in, in, in; widths 32, 1, 32, 4
  - meaning: command fields from initiator N
- sN_icb_cmd_valid  in  1 / sN_icb_cmd_ready  out  1  command handshake with initiator N
- sN_icb_rsp_rdata  out  32 / sN_icb_rsp_err  out  1  response fields to initiator N
- sN_icb_rsp_valid  out  1 / sN_icb_rsp_ready  in  1  response handshake with initiator N
- m_icb_cmd_addr / _read / _wdata / _wmask:
  - directions and widths: out, out, out, out; widths 32, 1, 32, 4
  - meaning: muxed command fields
- m_icb_cmd_valid  out  1 / m_icb_cmd_ready  in  1  command handshake with the target
- m_icb_rsp_rdata  in  32 / m_icb_rsp_err  in  1 / m_icb_rsp_valid  in  1 / m_icb_rsp_ready  out  1  response channel from the target

## Operation
- **Request vector:** req[N] = sN_icb_cmd_valid.
- **Round-robin priority:**
  - Register prio_ptr (2 bits, values 0..2) names the highest-priority initiator.
  - The search order is prio_ptr, prio_ptr+1, prio_ptr+2, modulo 3.
- **Grant:**
  - If lock=1, grant = lock_idx.
  - Otherwise, grant = the first requester in the search order.
  - If there are no requesters, no grant: m_icb_cmd_valid = 0.
- **Master command:**
  - m_icb_cmd_* fields = fields of the granted initiator; all zero when nothing is granted.
  - m_icb_cmd_valid = req[grant] & route_full_n.
- **Initiator ready:**
  - sN_icb_cmd_ready = (grant==N) & route_full_n & m_icb_cmd_ready.
  - Non-granted initiators see ready = 0.
- **Grant lock:**
  - If m_icb_cmd_valid=1 and m_icb_cmd_ready=0, set lock<=1 and lock_idx<=grant.
  - Clear lock on the command handshake.
  - While locked, a newly arriving higher-priority request is ignored.
- **Pointer update:** on a command handshake, prio_ptr <= (grant+1) mod 3. No update on idle cycles.
- **Route FIFO:**
  - Depth outstanding_depth, 2-bit entries holding the initiator index.
  - Written on every m_icb_cmd handshake; read on every m_icb_rsp handshake.
- **Response routing** (dst = FIFO head):
  - sN_icb_rsp_valid = route_empty_n & (dst==N) & m_icb_rsp_valid.
  - sN_icb_rsp_rdata / err = m_icb_rsp_rdata / err when dst==N, else 0.
  - m_icb_rsp_ready = route_empty_n & s[dst]_icb_rsp_ready.
- **Stray response:** a response arriving with the FIFO empty is not acknowledged (m_icb_rsp_ready=0). It is not flagged as an error.
- **Ordering:** the target must respond in command order, and this block relies on that.

## Timing
- **Reset values:** prio_ptr=0, lock=0, route FIFO empty.
  - All sN_icb_rsp_valid = 0, m_icb_rsp_ready = 0.
  - m_icb_cmd_valid = 0 until a request arrives.
- **Command path:** combinational, 0 cycles from sN valid to m valid. Registers change only on the clk edge after a handshake.
- **Response path:** combinational, 0 cycles.
- **FIFO full:**
  - m_icb_cmd_valid=0 and all sN_icb_cmd_ready=0.
  - Full blocks the write even if a response retires in the same cycle; there is no write-through-read bypass.
  - The lock is not set while the FIFO is full, because valid is gated.
- **FIFO empty:** a command and its response may not complete in the same cycle, since the route entry becomes visible the next cycle. Minimum round trip is 1 cycle.
- **Simultaneous command and response handshake** with the FIFO neither full nor empty: one push and one pop in the same cycle, occupancy unchanged.
- **Locked initiator drops valid before the handshake:** this is a protocol violation. The lock stays until the handshake and is not recovered.
- **resetn asserted mid-transaction:**
  - Outstanding entries are discarded and the pointer and lock clear immediately.
  - Responses still in flight are then treated as stray.

## Structure
- **Shared package `icb_bus_pkg`:**
  - ICB field widths (ADDR_W=32, DATA_W=32, MASK_W=4).
  - ICB_ARB_PORTS=3.
  - Initiator index width IDX_W=2.
- **Route FIFO:** instantiate the existing `fifo_based_on_regs` with fwft_mode "true", low_latency_mode "false", fifo_depth = outstanding_depth, fifo_data_width = 2. No new FIFO module.
- **Arbiter sub-module `rr_arb_3`:** holds prio_ptr and lock state, takes req[2:0], the handshake and the stall, and outputs the grant index and grant valid.

## Test plan
- **Single initiator:** s1 issues reads to 0x4000_0000 and 0x4000_0004 with an always-ready target that returns rdata 0xA5A5_0001 then 0xA5A5_0002. Expect s1 to receive both, in order, err=0, with s0 and s2 rsp_valid never set.
- **Round-robin:** s0, s1 and s2 all hold valid, target always ready. Expect command grant order 0,1,2,0,1,2, one handshake per cycle.
- **Lock:** s2 is granted while m_icb_cmd_ready=0 for 3 cycles and s0 asserts valid in cycle 1. Expect m_icb_cmd_addr to hold s2's address for all 3 cycles, s2 to handshake in cycle 4, and s0 to be granted in cycle 5.
- **Full FIFO:** outstanding_depth=4, 4 commands issued, target withholds responses. Expect m_icb_cmd_valid=0 and all sN cmd_ready=0. After one response handshake, a fifth command is accepted on the next cycle.
- **Response backpressure:** the response is destined to s0 with s0_icb_rsp_ready=0 for 2 cycles. Expect m_icb_rsp_ready=0 for those 2 cycles, with rdata and err stable at s0.
- **Reset mid-flight:** pull resetn low while 2 commands are outstanding. Expect route_empty_n=0, prio_ptr=0 and all rsp_valid=0 immediately.
